// File: rtl/fifo_fwft_reader.sv
// Read-side master for sync_fifo: prefetches into a 2-entry buffer and presents
// the words as a first-word-fall-through valid/ready stream.
module fifo_fwft_reader #(
    parameter int DWIDTH    = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 fifo_rden,
    input  logic                 fifo_empty,
    input  logic [DWIDTH-1:0]    fifo_dout,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DWIDTH-1:0]    m_data,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

    occ_t              occ;
    logic              inflight;
    logic [DWIDTH-1:0] entry0;
    logic [DWIDTH-1:0] entry1;
    logic              pop;
    logic              fill;
    logic [2:0]        credit;

    assign pop  = m_valid && m_ready;
    assign fill = inflight;

    // Words that will be held after this edge if no new read is issued; the
    // read strobe is combinational from m_ready so a draining buffer refills
    // without a bubble.
    assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rden = rstn && !flush && !fifo_empty && (credit < 3'd2);

    assign m_data = entry0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ      <= S_EMPTY;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            entry0   <= '0;
            entry1   <= '0;
            xfer_cnt <= '0;
        end else begin
            inflight <= fifo_rden;
            if (pop) xfer_cnt <= xfer_cnt + 1'b1;

            if (flush) begin
                occ     <= S_EMPTY;
                m_valid <= 1'b0;
            end else begin
                unique case (occ)
                    S_EMPTY: begin
                        if (fill) begin
                            entry0  <= fifo_dout;
                            occ     <= S_ONE;
                            m_valid <= 1'b1;
                        end
                    end
                    S_ONE: begin
                        if (fill && pop) begin
                            entry0 <= fifo_dout;
                        end else if (fill) begin
                            entry1 <= fifo_dout;
                            occ    <= S_TWO;
                        end else if (pop) begin
                            occ     <= S_EMPTY;
                            m_valid <= 1'b0;
                        end
                    end
                    S_TWO: begin
                        if (pop) begin
                            entry0 <= entry1;
                            if (fill) entry1 <= fifo_dout;
                            else      occ    <= S_ONE;
                        end
                    end
                    default: begin
                        occ     <= S_EMPTY;
                        m_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The credit rule must never let a word land on a full buffer.
    a_no_overfill: assert property (@(posedge clk) disable iff (!rstn)
        !(fill && !pop && !flush && occ == S_TWO));

endmodule
